// File: rtl/vga_pkg.sv
// Shared register map, reset constants and queue entry layout for the MPU video RAM write path.
// Entry layout is {address, data}, matching the write queue head bus.
package vga_pkg;

  localparam int VRAM_ADDR_W = 17;

  localparam logic [2:0] REG_ADDR_LO = 3'd0;
  localparam logic [2:0] REG_ADDR_HI = 3'd1;
  localparam logic [2:0] REG_ADDR_UP = 3'd2;
  localparam logic [2:0] REG_DATA    = 3'd3;
  localparam logic [2:0] REG_INCR    = 3'd4;
  localparam logic [2:0] REG_CLR_OVF = 3'd5;

  localparam logic [7:0] RESET_INCREMENT = 8'd1;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] address;
    logic [7:0]             data;
  } queueEntry_t;

endpackage

// File: rtl/write_queue.sv
// First-word fall-through queue: head visible with zero latency, push/pop take effect at the clock edge.
// A push into a full queue is refused unless a pop happens in the same cycle; pops while empty are ignored.
module write_queue
  import vga_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = VRAM_ADDR_W + 8
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             pushValid,
  input  logic [WIDTH-1:0] pushData,
  input  logic             popRequest,
  output logic [WIDTH-1:0] headData,
  output logic             empty,
  output logic             full,
  output logic             pushAccepted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             popFire;
  logic             pushFire;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign popFire  = popRequest && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign pushFire = pushValid && (!full || popFire);

  assign pushAccepted = pushFire;
  assign headData     = empty ? '0 : storage[rdPtr];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushFire) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (popFire) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({pushFire, popFire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (pushFire) begin
      storage[wrPtr] <= pushData;
    end
  end

endmodule

// File: rtl/mpu_write_port.sv
// MPU write port: two-flop strobe sync, register decode, FWFT write queue; a write commits 3 cycles after strobe rise.
// Pushes into a full queue are dropped and set sticky overflow; MPU_AUTO_INCREMENT_EN enables address auto-increment.
module mpu_write_port
  import vga_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = VRAM_ADDR_W
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              chipSelect,
  input  logic              writeEnable,
  input  logic [2:0]        registerSelect,
  input  logic [7:0]        registerData,
  input  logic              queueReadRequest,
  output logic [ADDR_W+7:0] queueReadBus,
  output logic              queueReadEmpty,
  output logic              queueFull,
  output logic              overflow
);

  logic              strobeAsync;
  logic              sync0;
  logic              sync1;
  logic              sync2;
  logic [1:0]        syncPrimed;
  logic              strobeArmed;
  logic              commit;

  logic              wrAddrLo;
  logic              wrAddrHi;
  logic              wrAddrUp;
  logic              wrData;
  logic              wrClrOvf;

  logic [ADDR_W-1:0] address;
  logic [ADDR_W+7:0] pushEntry;
  logic              pushAccepted;
  logic              pushDropped;

`ifdef MPU_AUTO_INCREMENT_EN
  logic [7:0]        increment;
  logic              wrIncr;
`endif

  assign strobeAsync = chipSelect && writeEnable;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      syncPrimed <= 2'b00;
    end else begin
      sync0      <= strobeAsync;
      sync1      <= sync0;
      sync2      <= sync1;
      syncPrimed <= {syncPrimed[0], 1'b1};
    end
  end

  // Arm only once a genuinely sampled low strobe has reached sync1, so a
  // strobe still held across reset release must drop and rise again.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      strobeArmed <= 1'b0;
    end else if (syncPrimed[1] && !sync1) begin
      strobeArmed <= 1'b1;
    end
  end

  assign commit = sync1 && !sync2 && strobeArmed;

  assign wrAddrLo = commit && (registerSelect == REG_ADDR_LO);
  assign wrAddrHi = commit && (registerSelect == REG_ADDR_HI);
  assign wrAddrUp = commit && (registerSelect == REG_ADDR_UP);
  assign wrData   = commit && (registerSelect == REG_DATA);
  assign wrClrOvf = commit && (registerSelect == REG_CLR_OVF);

`ifdef MPU_AUTO_INCREMENT_EN
  assign wrIncr = commit && (registerSelect == REG_INCR);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      increment <= RESET_INCREMENT;
    end else if (wrIncr) begin
      increment <= registerData;
    end
  end
`endif

  // Upper address register covers bits 16 and above; ADDR_W is expected in 17..24.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      address <= '0;
    end else begin
      if (wrAddrLo) begin
        address[7:0] <= registerData;
      end
      if (wrAddrHi) begin
        address[15:8] <= registerData;
      end
      if (wrAddrUp) begin
        address[ADDR_W-1:16] <= registerData[ADDR_W-17:0];
      end
`ifdef MPU_AUTO_INCREMENT_EN
      if (pushAccepted) begin
        address <= address + ADDR_W'(increment);
      end
`endif
    end
  end

  assign pushEntry   = {address, registerData};
  assign pushDropped = wrData && !pushAccepted;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      overflow <= 1'b0;
    end else if (pushDropped) begin
      overflow <= 1'b1;
    end else if (wrClrOvf) begin
      overflow <= 1'b0;
    end
  end

  write_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + 8)
  ) u_writeQueue (
    .clock        (clock),
    .resetN       (resetN),
    .pushValid    (wrData),
    .pushData     (pushEntry),
    .popRequest   (queueReadRequest),
    .headData     (queueReadBus),
    .empty        (queueReadEmpty),
    .full         (queueFull),
    .pushAccepted (pushAccepted)
  );

endmodule

// File: tb/tb_mpu_write_port.sv
// Scoreboard bench for mpu_write_port: expected entries queued at each register-3 write, compared at each pop.
`timescale 1ns/1ps
module tb_mpu_write_port;
  import vga_pkg::*;

  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 17;
  localparam int ENTRY_W = ADDR_W + 8;

  logic               clock = 1'b0;
  logic               resetN = 1'b0;
  logic               chipSelect = 1'b0;
  logic               writeEnable = 1'b0;
  logic [2:0]         registerSelect = 3'd0;
  logic [7:0]         registerData = 8'd0;
  logic               queueReadRequest = 1'b0;
  logic [ENTRY_W-1:0] queueReadBus;
  logic               queueReadEmpty;
  logic               queueFull;
  logic               overflow;

  int                 checks = 0;
  int                 errors = 0;

  logic [ENTRY_W-1:0] expQ[$];
  logic [ADDR_W-1:0]  modelAddr;
  logic [7:0]         modelInc;
  logic               modelOvf;
  int                 modelCount;
  logic               preCommitEmpty;
  logic               postCommitEmpty;
  queueEntry_t        headView;

  always #5 clock = ~clock;

  mpu_write_port #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock            (clock),
    .resetN           (resetN),
    .chipSelect       (chipSelect),
    .writeEnable      (writeEnable),
    .registerSelect   (registerSelect),
    .registerData     (registerData),
    .queueReadRequest (queueReadRequest),
    .queueReadBus     (queueReadBus),
    .queueReadEmpty   (queueReadEmpty),
    .queueFull        (queueFull),
    .overflow         (overflow)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkStatus(input string tag);
    checkVal({tag, "_empty"}, {31'd0, queueReadEmpty}, {31'd0, modelCount == 0});
    checkVal({tag, "_full"}, {31'd0, queueFull}, {31'd0, modelCount == DEPTH});
    checkVal({tag, "_ovf"}, {31'd0, overflow}, {31'd0, modelOvf});
  endtask

  // One complete MPU access; optional consumer pop lands on the commit edge.
  task automatic mpuWrite(input logic [2:0] r, input logic [7:0] d, input bit coPop);
    logic [ENTRY_W-1:0] popped;
    @(negedge clock);
    registerSelect = r;
    registerData   = d;
    chipSelect     = 1'b1;
    writeEnable    = 1'b1;
    @(negedge clock);
    @(negedge clock);
    preCommitEmpty = queueReadEmpty;
    if (coPop) begin
      if (expQ.size() > 0) begin
        popped = expQ.pop_front();
        checkVal("copop_head", {7'd0, queueReadBus}, {7'd0, popped});
        modelCount--;
      end
      queueReadRequest = 1'b1;
    end
    @(negedge clock);
    postCommitEmpty  = queueReadEmpty;
    queueReadRequest = 1'b0;
    chipSelect       = 1'b0;
    writeEnable      = 1'b0;
    case (r)
      3'd0: modelAddr[7:0]  = d;
      3'd1: modelAddr[15:8] = d;
      3'd2: modelAddr[16]   = d[0];
      3'd3: begin
        if (modelCount < DEPTH) begin
          expQ.push_back({modelAddr, d});
          modelCount++;
`ifdef MPU_AUTO_INCREMENT_EN
          modelAddr = modelAddr + {9'd0, modelInc};
`endif
        end else begin
          modelOvf = 1'b1;
        end
      end
      3'd4: begin
`ifdef MPU_AUTO_INCREMENT_EN
        modelInc = d;
`endif
      end
      3'd5: modelOvf = 1'b0;
      default: ;
    endcase
    repeat (3) @(negedge clock);
  endtask

  task automatic popCheck(input string tag);
    logic [ENTRY_W-1:0] e;
    @(negedge clock);
    if (expQ.size() == 0) begin
      checkVal({tag, "_empty"}, {31'd0, queueReadEmpty}, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkVal(tag, {7'd0, queueReadBus}, {7'd0, e});
      modelCount--;
      queueReadRequest = 1'b1;
      @(negedge clock);
      queueReadRequest = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef MPU_AUTO_INCREMENT_EN
    logic [ADDR_W-1:0] wrapAddr [3];
    wrapAddr[0] = 17'h1FFFF;
    wrapAddr[1] = 17'h00001;
    wrapAddr[2] = 17'h00003;
`endif
    modelAddr  = '0;
    modelInc   = RESET_INCREMENT;
    modelOvf   = 1'b0;
    modelCount = 0;

    repeat (3) @(negedge clock);
    checkVal("rst_empty", {31'd0, queueReadEmpty}, 32'd1);
    checkVal("rst_full", {31'd0, queueFull}, 32'd0);
    checkVal("rst_ovf", {31'd0, overflow}, 32'd0);
    checkVal("rst_bus", {7'd0, queueReadBus}, 32'd0);
    resetN = 1'b1;
    repeat (4) @(negedge clock);

    // Address assembly and first push, including commit edge timing.
    mpuWrite(3'd0, 8'h34, 1'b0);
    mpuWrite(3'd1, 8'h12, 1'b0);
    mpuWrite(3'd2, 8'h01, 1'b0);
    checkVal("no_push_before_reg3", {31'd0, queueReadEmpty}, 32'd1);
    mpuWrite(3'd3, 8'hAA, 1'b0);
    checkVal("empty_before_3rd_edge", {31'd0, preCommitEmpty}, 32'd1);
    checkVal("pushed_at_3rd_edge", {31'd0, postCommitEmpty}, 32'd0);
    checkVal("first_entry", {7'd0, queueReadBus}, 32'h011234AA);
    headView = queueReadBus;
    checkVal("first_entry_addr", {15'd0, headView.address}, 32'h00011234);
    checkStatus("after_first");
    popCheck("pop_first");
    checkStatus("after_pop_first");

    // Unused registers, increment register, ordering of two pushes.
    mpuWrite(3'd6, 8'h00, 1'b0);
    mpuWrite(3'd7, 8'h00, 1'b0);
    checkStatus("after_reg67");
    mpuWrite(3'd4, 8'h05, 1'b0);
    mpuWrite(3'd3, 8'h55, 1'b0);
    mpuWrite(3'd3, 8'h66, 1'b0);
    checkStatus("two_pushed");
    popCheck("pop_order0");
    popCheck("pop_order1");

    // Pop request held while empty must not disturb the queue.
    @(negedge clock);
    queueReadRequest = 1'b1;
    repeat (4) @(negedge clock);
    checkStatus("hold_pop_empty");
    checkVal("hold_pop_bus", {7'd0, queueReadBus}, 32'd0);
    queueReadRequest = 1'b0;
    mpuWrite(3'd3, 8'h5A, 1'b0);
    checkStatus("after_hold_push");
    popCheck("pop_after_hold");

    // Fill to DEPTH, drop the next, clear overflow, then push coincident with pop.
    mpuWrite(3'd0, 8'h00, 1'b0);
    mpuWrite(3'd1, 8'h20, 1'b0);
    mpuWrite(3'd2, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      mpuWrite(3'd3, 8'(i + 1), 1'b0);
      if (i == DEPTH - 2) checkVal("not_full_at_15", {31'd0, queueFull}, 32'd0);
      if (i == DEPTH - 1) checkVal("full_at_16", {31'd0, queueFull}, 32'd1);
    end
    checkVal("ovf_after_drop", {31'd0, overflow}, 32'd1);
    checkStatus("after_drop");
    mpuWrite(3'd5, 8'h00, 1'b0);
    checkVal("ovf_cleared", {31'd0, overflow}, 32'd0);
    mpuWrite(3'd3, 8'hEE, 1'b1);
    checkVal("copop_full_kept", {31'd0, queueFull}, 32'd1);
    checkVal("copop_no_ovf", {31'd0, overflow}, 32'd0);
    checkStatus("after_copop");
    for (int i = 0; i < DEPTH; i++) popCheck("drain");
    checkStatus("drained");

`ifdef MPU_AUTO_INCREMENT_EN
    // Address wraps modulo 2^ADDR_W with increment 2.
    mpuWrite(3'd4, 8'h02, 1'b0);
    mpuWrite(3'd0, 8'hFF, 1'b0);
    mpuWrite(3'd1, 8'hFF, 1'b0);
    mpuWrite(3'd2, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) mpuWrite(3'd3, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkVal("wrap_addr", {15'd0, queueReadBus[ENTRY_W-1:8]}, {15'd0, wrapAddr[i]});
      popCheck("wrap_pop");
    end
`endif

    // Reset with entries queued and an access in flight.
    for (int i = 0; i < 5; i++) mpuWrite(3'd3, 8'(8'hB0 + i), 1'b0);
    checkStatus("five_pushed");
    @(negedge clock);
    registerSelect = 3'd3;
    registerData   = 8'h99;
    chipSelect     = 1'b1;
    writeEnable    = 1'b1;
    @(negedge clock);
    resetN = 1'b0;
    #1;
    checkVal("midrst_empty", {31'd0, queueReadEmpty}, 32'd1);
    checkVal("midrst_full", {31'd0, queueFull}, 32'd0);
    checkVal("midrst_ovf", {31'd0, overflow}, 32'd0);
    checkVal("midrst_bus", {7'd0, queueReadBus}, 32'd0);
    expQ.delete();
    modelCount = 0;
    modelAddr  = '0;
    modelInc   = RESET_INCREMENT;
    modelOvf   = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    repeat (6) @(negedge clock);
    checkVal("held_strobe_no_commit", {31'd0, queueReadEmpty}, 32'd1);
    chipSelect  = 1'b0;
    writeEnable = 1'b0;
    repeat (3) @(negedge clock);
    mpuWrite(3'd3, 8'h77, 1'b0);
    checkVal("post_reset_addr", {7'd0, queueReadBus}, 32'h00000077);
    popCheck("pop_post_reset");
    checkStatus("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
